board_validator: RTL

- Downstream consumer of the game RAM's read-only port B. Continuously scans the 4x4 board and drives the win indicator.
- Each pass reads all four row words, then checks every row, column and 2x2 box for exactly the digits 1..4.
- Reports win, board-full and conflict status to the top level. Drives nothing back into the RAM except the read address.

---
 rtl/sudoku_pkg.sv | 41 ++++
 rtl/group_check.sv | 26 ++
 rtl/board_validator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants, cell field layout, scan FSM states and digit decode helpers
// for the 4x4 sudoku board logic.
package sudoku_pkg;

    localparam int N_ROWS    = 4;
    localparam int N_COLS    = 4;
    localparam int CELL_W    = 5;
    localparam int ROW_W     = 20;
    localparam int VAL_LSB   = 0;
    localparam int VAL_W     = 4;
    localparam int PROT_BIT  = 4;
    localparam int MIN_DIGIT = 1;
    localparam int MAX_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        EVAL  = 2'd3
    } state_t;

    // Digits 1..4 map to one-hot bit (v-1); empty and illegal values map to 0000.
    function automatic logic [3:0] digit_onehot(input logic [VAL_W-1:0] v);
        case (v)
            4'd1:    return 4'b0001;
            4'd2:    return 4'b0010;
            4'd3:    return 4'b0100;
            4'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_digit(input logic [VAL_W-1:0] v);
        return (v >= VAL_W'(MIN_DIGIT)) && (v <= VAL_W'(MAX_DIGIT));
    endfunction

    function automatic logic is_illegal(input logic [VAL_W-1:0] v);
        return v > VAL_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/group_check.sv
// Checks one row, column or box: complete set of 1..4, duplicates, illegal values.
module group_check
    import sudoku_pkg::*;
(
    input  logic [VAL_W-1:0] a,
    input  logic [VAL_W-1:0] b,
    input  logic [VAL_W-1:0] c,
    input  logic [VAL_W-1:0] d,
    output logic             ok,
    output logic             dup,
    output logic             illegal
);

    logic [3:0] oh_a, oh_b, oh_c, oh_d;

    assign oh_a = digit_onehot(a);
    assign oh_b = digit_onehot(b);
    assign oh_c = digit_onehot(c);
    assign oh_d = digit_onehot(d);

    assign ok  = &(oh_a | oh_b | oh_c | oh_d);
    assign dup = |((oh_a & oh_b) | (oh_a & oh_c) | (oh_a & oh_d) |
                   (oh_b & oh_c) | (oh_b & oh_d) | (oh_c & oh_d));
    assign illegal = is_illegal(a) | is_illegal(b) | is_illegal(c) | is_illegal(d);

endmodule

// File: rtl/board_validator.sv
// Repeatedly reads the four board rows from RAM port B, then checks rows,
// columns and boxes and updates win / full / conflict status once per pass.
module board_validator
    import sudoku_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter bit STICKY_WIN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [1:0]       ram_addr,
    input  logic [ROW_W-1:0] ram_dat,
    input  logic             scan_en,
    output logic             game_complete,
    output logic             board_full,
    output logic             conflict,
    output logic             pass_done,
    output state_t           fsm_state
);

    state_t     state_q, state_d;
    logic [1:0] cnt_q;
    logic [1:0] hold_q;
    logic [1:0] drain_q;
    logic       issuing;

    logic [RD_LAT-1:0] vld_pipe;
    logic [1:0]        addr_pipe [RD_LAT];
    logic [VAL_W-1:0]  vals_q [N_ROWS][N_COLS];

    logic [N_ROWS*N_COLS-1:0] unused_prot;
    logic [11:0] ok_v, dup_v, ill_v;
    logic        full_next, conflict_next, win_next;

    assign fsm_state = state_q;
    assign issuing   = (state_q == ISSUE);
    assign ram_addr  = issuing ? cnt_q : hold_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan_en) state_d = ISSUE;
            ISSUE:   if (cnt_q == 2'd3) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'(RD_LAT - 1)) state_d = EVAL;
            EVAL:    state_d = scan_en ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issued address and valid bit travel RD_LAT stages so each row is captured
    // exactly when its word is on ram_dat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            hold_q  <= 2'd0;
            drain_q <= 2'd0;
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= 2'd0;
            for (int r = 0; r < N_ROWS; r++)
                for (int c = 0; c < N_COLS; c++) vals_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            if (issuing) begin
                cnt_q  <= cnt_q + 2'd1;
                hold_q <= cnt_q;
            end
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
            vld_pipe[0]  <= issuing;
            addr_pipe[0] <= cnt_q;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (vld_pipe[RD_LAT-1]) begin
                for (int c = 0; c < N_COLS; c++)
                    vals_q[addr_pipe[RD_LAT-1]][c] <= ram_dat[c*CELL_W + VAL_LSB +: VAL_W];
            end
        end
    end

    // Write-protect flags play no part in validation.
    always_comb begin
        unused_prot = '0;
        for (int c = 0; c < N_COLS; c++) unused_prot[c] = ram_dat[c*CELL_W + PROT_BIT];
    end

    for (genvar g = 0; g < 4; g++) begin : g_groups
        localparam int R0 = 2 * (g / 2);
        localparam int C0 = 2 * (g % 2);

        group_check u_row (
            .a(vals_q[g][0]), .b(vals_q[g][1]), .c(vals_q[g][2]), .d(vals_q[g][3]),
            .ok(ok_v[g]), .dup(dup_v[g]), .illegal(ill_v[g])
        );
        group_check u_col (
            .a(vals_q[0][g]), .b(vals_q[1][g]), .c(vals_q[2][g]), .d(vals_q[3][g]),
            .ok(ok_v[4+g]), .dup(dup_v[4+g]), .illegal(ill_v[4+g])
        );
        group_check u_box (
            .a(vals_q[R0][C0]), .b(vals_q[R0][C0+1]),
            .c(vals_q[R0+1][C0]), .d(vals_q[R0+1][C0+1]),
            .ok(ok_v[8+g]), .dup(dup_v[8+g]), .illegal(ill_v[8+g])
        );
    end

    always_comb begin
        full_next = 1'b1;
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
                full_next = full_next & is_digit(vals_q[r][c]);
    end

    assign conflict_next = (|dup_v) | (|ill_v);
    assign win_next      = full_next & (&ok_v) & ~conflict_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            game_complete <= 1'b0;
            board_full    <= 1'b0;
            conflict      <= 1'b0;
            pass_done     <= 1'b0;
        end else begin
            pass_done <= (state_q == EVAL);
            if (state_q == EVAL) begin
                board_full    <= full_next;
                conflict      <= conflict_next;
                game_complete <= STICKY_WIN ? (game_complete | win_next) : win_next;
            end
        end
    end

endmodule
